// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         MAXPW_DEF   = 8;
  localparam logic [7:0] DEF_PATTERN = 8'h15;
  localparam logic [3:0] DEF_LEN     = 4'd5;
  localparam logic       DEF_OVERLAP = 1'b0;

endpackage

// File: rtl/seq_det_match.sv
// History register, fill tracker and pattern comparator for one serial bit
// per cycle. In non-overlap mode a match discards the history so the next
// match must be built entirely from fresh bits.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAXPW = MAXPW_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             bit_p0,
  input  logic             vld_p0,
  input  logic [MAXPW-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  output logic             match
);

  localparam int FW = $clog2(MAXPW + 1);

  logic [MAXPW-1:0] hist;
  logic [FW-1:0]    fill;
  logic [MAXPW-1:0] hist_nxt;
  logic [FW-1:0]    fill_nxt;
  logic [MAXPW:0]   mask_w;
  logic [MAXPW-1:0] mask;

  // Next history/fill for the incoming bit and the match decision on it.
  always_comb begin
    hist_nxt = {hist[MAXPW-2:0], bit_p0};
    fill_nxt = (int'(fill) >= MAXPW) ? fill : fill + FW'(1);
    mask_w   = ((MAXPW + 1)'(1) << cfg_len) - (MAXPW + 1)'(1);
    mask     = mask_w[MAXPW-1:0];
    match    = vld_p0 && (int'(fill_nxt) >= int'(cfg_len)) &&
               ((hist_nxt & mask) == (cfg_pattern & mask));
  end

  // History and fill update; cleared by reset and by an accepted config.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (vld_p0) begin
      hist <= hist_nxt;
      fill <= (match && !cfg_overlap) ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte-stream front end and controller for the programmable serial pattern
// detector: valid/ready byte intake, MSB-first serialiser, runtime config
// register, saturating match counter and registered hit/cfg_err pulses.
// Optional macro SEQ_DET_CTRL_POS_EN adds hit_pos and hit_byte outputs.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DW    = 8,
  parameter int MAXPW = MAXPW_DEF,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [MAXPW-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             hit,
  output logic [CNTW-1:0]  hit_count,
  output logic             cfg_err
`ifdef SEQ_DET_CTRL_POS_EN
  ,
  output logic [$clog2(DW)-1:0] hit_pos,
  output logic [15:0]           hit_byte
`endif
);

  localparam int IW = $clog2(DW);

  state_t           state;
  logic [IW-1:0]    bit_idx;
  logic [DW-1:0]    sreg;
  logic [MAXPW-1:0] pat_q;
  logic [3:0]       len_q;
  logic             ov_q;
  logic             last_bit;
  logic             accept;
  logic             cfg_ok;
  logic             bit_p0;
  logic             vld_p0;
  logic             match;

  assign last_bit = (state == SHIFT) && (bit_idx == IW'(DW - 1));
  assign in_ready = en & ~cfg_we & ((state == IDLE) | last_bit);
  assign accept   = in_valid & in_ready;
  assign cfg_ok   = cfg_we && (state == IDLE) && (cfg_len != '0) &&
                    (int'(cfg_len) <= MAXPW);
  assign busy     = (state == SHIFT);

  // Serialiser output stage: current MSB goes to the matcher each SHIFT cycle.
  assign bit_p0   = sreg[DW-1];
  assign vld_p0   = (state == SHIFT);

  // Shift register: load on accept, shift left while serialising.
  always_ff @(posedge clk) begin
    if (accept) begin
      sreg <= in_data;
    end else if (state == SHIFT) begin
      sreg <= {sreg[DW-2:0], 1'b0};
    end
  end

  // Control FSM, config register, match counter and output pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_idx   <= '0;
      pat_q     <= MAXPW'(DEF_PATTERN);
      len_q     <= DEF_LEN;
      ov_q      <= DEF_OVERLAP;
      hit       <= 1'b0;
      hit_count <= '0;
      cfg_err   <= 1'b0;
    end else begin
      hit     <= match;
      cfg_err <= cfg_we & ~cfg_ok;
      if (cfg_ok) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        ov_q      <= cfg_overlap;
        hit_count <= '0;
      end else if (match && (hit_count != '1)) begin
        hit_count <= hit_count + CNTW'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bit_idx <= '0;
            if (!accept) begin
              state <= IDLE;
            end
          end else begin
            bit_idx <= bit_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_det_match #(
    .MAXPW(MAXPW)
  ) u_match (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (cfg_ok),
    .bit_p0     (bit_p0),
    .vld_p0     (vld_p0),
    .cfg_pattern(pat_q),
    .cfg_len    (len_q),
    .cfg_overlap(ov_q),
    .match      (match)
  );

`ifdef SEQ_DET_CTRL_POS_EN
  logic [15:0] byte_cnt;

  // Accepted-byte counter and position/byte capture on each match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      hit_pos  <= '0;
      hit_byte <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      if (match) begin
        hit_pos  <= IW'(DW - 1) - bit_idx;
        hit_byte <= byte_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-queue reference model predicts
// hits and cfg_err pulses, a monitor pops and compares them as they appear.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       hit;
  logic [7:0] hit_count;
  logic       cfg_err;
`ifdef SEQ_DET_CTRL_POS_EN
  logic [2:0]  hit_pos;
  logic [15:0] hit_byte;
`endif

  seq_det_ctrl #(.DW(8), .MAXPW(8), .CNTW(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .hit(hit), .hit_count(hit_count), .cfg_err(cfg_err)
`ifdef SEQ_DET_CTRL_POS_EN
    , .hit_pos(hit_pos), .hit_byte(hit_byte)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int c; int cnt; int pos; int byt; } exp_t;

  exp_t hq[$];
  int   cq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   nhits = 0;
  int   nerr = 0;
  int   busy_cyc = 0;
  logic last_acc;
  logic [7:0] bq[$];

  // reference model state
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ov;
  int         m_cnt;
  int         m_rem;
  logic [7:0] m_cur;
  int         m_bytes;
  logic       mh[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'h15; m_len = 5; m_ov = 1'b0; m_cnt = 0; m_rem = 0;
    m_bytes = 0; mh.delete(); hq.delete(); cq.delete();
  endtask

  task automatic model_bit(input logic b, input int pos);
    logic ok;
    mh.push_back(b);
    if (mh.size() > 8) void'(mh.pop_front());
    if (mh.size() >= m_len) begin
      ok = 1'b1;
      for (int k = 0; k < m_len; k++)
        if (mh[mh.size() - 1 - k] != m_pat[k]) ok = 1'b0;
      if (ok) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        hq.push_back('{cyc + 1, m_cnt, pos, m_bytes});
        if (!m_ov) mh.delete();
      end
    end
  endtask

  // One clock: drive inputs just after negedge, predict, wait next negedge.
  task automatic tick(input logic e, input logic we, input logic [7:0] pat,
                      input logic [3:0] ln, input logic ov, input logic v,
                      input logic [7:0] d);
    logic er;
    int   rem0;
    en = e; cfg_we = we; cfg_pattern = pat; cfg_len = ln;
    cfg_overlap = ov; in_valid = v; in_data = d;
    #1;
    rem0 = m_rem;
    er = e && !we && (rem0 <= 1);
    chk("in_ready", int'(in_ready), int'(er));
    chk("busy", int'(busy), int'(rem0 > 0));
    busy_cyc += int'(busy);
    last_acc = v && er;
    if (rem0 > 0) begin
      model_bit(m_cur[rem0-1], rem0 - 1);
      m_rem--;
    end
    if (we) begin
      if (rem0 == 0 && ln >= 1 && ln <= 8) begin
        m_pat = pat; m_len = int'(ln); m_ov = ov; mh.delete(); m_cnt = 0;
      end else begin
        cq.push_back(cyc + 1);
      end
    end
    if (last_acc) begin
      m_cur = d; m_rem = 8; m_bytes = (m_bytes + 1) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
    tick(1'b1, 1'b1, pat, ln, ov, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic send_stream();
    busy_cyc = 0;
    while (bq.size() > 0) begin
      tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, bq[0]);
      if (last_acc) void'(bq.pop_front());
    end
    while (m_rem > 0) idle(1);
    idle(2);
  endtask

  // Monitor: pop expected entries whenever the DUT pulses hit or cfg_err.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (hit) begin
        nhits++;
        if (hq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL hit_unexpected: hit=1 at cycle %0d, required none", cyc);
        end else begin
          e = hq.pop_front();
          chk("hit_cycle", cyc, e.c);
          chk("hit_count", int'(hit_count), e.cnt);
`ifdef SEQ_DET_CTRL_POS_EN
          chk("hit_pos", int'(hit_pos), e.pos);
          chk("hit_byte", int'(hit_byte), e.byt);
`endif
        end
      end
      if (hq.size() > 0 && hq[0].c <= cyc) begin
        vectors++; miscompares++;
        $display("FAIL hit_missing: hit=0 at cycle %0d, required hit at %0d", cyc, hq[0].c);
        void'(hq.pop_front());
      end
      if (cfg_err) begin
        nerr++;
        if (cq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cfg_err_unexpected: cfg_err=1 at cycle %0d, required 0", cyc);
        end else begin
          chk("cfg_err_cycle", cyc, cq.pop_front());
        end
      end
      if (cq.size() > 0 && cq[0] <= cyc) begin
        vectors++; miscompares++;
        $display("FAIL cfg_err_missing: cfg_err=0 at cycle %0d, required 1", cyc);
        void'(cq.pop_front());
      end
    end
  end

  initial begin
    int h0, e0;
    rstn = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rstn = 1'b1;

    // single byte matching the default pattern
    h0 = nhits; bq.push_back(8'h15); send_stream();
    chk("t1_hits", nhits - h0, 1);
    chk("t1_count", int'(hit_count), 1);
    chk("t1_busy_cycles", busy_cyc, 8);

    // back-to-back bytes, non-overlapping
    cfg(8'h15, 4'd5, 1'b0);
    h0 = nhits; bq.push_back(8'h55); bq.push_back(8'h55); send_stream();
    chk("t2_hits", nhits - h0, 2);
    chk("t2_count", int'(hit_count), 2);
    chk("t2_busy_cycles", busy_cyc, 16);

    // same stream, overlapping
    cfg(8'h15, 4'd5, 1'b1);
    h0 = nhits; bq.push_back(8'h55); bq.push_back(8'h55); send_stream();
    chk("t3_hits", nhits - h0, 6);
    chk("t3_count", int'(hit_count), 6);

    // rejected config: length zero in IDLE
    cfg(8'h15, 4'd5, 1'b0);
    e0 = nerr; cfg(8'h01, 4'd0, 1'b1);
    chk("t4_cfg_err", nerr - e0, 1);
    h0 = nhits; bq.push_back(8'h15); send_stream();
    chk("t4_hits", nhits - h0, 1);
    chk("t4_count", int'(hit_count), 1);

    // rejected config: write during SHIFT
    e0 = nerr; h0 = nhits;
    tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 8'h15);
    idle(2);
    tick(1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 8'h00);
    while (m_rem > 0) idle(1);
    idle(2);
    chk("t5_cfg_err", nerr - e0, 1);
    chk("t5_hits", nhits - h0, 1);
    chk("t5_count", int'(hit_count), 2);

    // counter saturation
    cfg(8'h01, 4'd1, 1'b1);
    h0 = nhits;
    for (int i = 0; i < 32; i++) bq.push_back(8'hFF);
    send_stream();
    chk("t6_hits", nhits - h0, 256);
    chk("t6_count", int'(hit_count), 255);

    // asynchronous reset mid-byte
    tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 8'h15);
    idle(3);
    #2 rstn = 1'b0;
    #1;
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_hit", int'(hit), 0);
    chk("t7_rst_count", int'(hit_count), 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    h0 = nhits; bq.push_back(8'h15); send_stream();
    chk("t7_hits", nhits - h0, 1);
    chk("t7_count", int'(hit_count), 1);

    // randomized traffic with occasional config writes
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom);
      tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 24) == 0),
           8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), d);
    end
    while (m_rem > 0) idle(1);
    idle(3);
    chk("final_hit_queue_empty", hq.size(), 0);
    chk("final_cfg_err_queue_empty", cq.size(), 0);
    chk("final_count", int'(hit_count), m_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Byte-stream front end and controller for a programmable serial pattern detector, in the same family as the team's Mealy sequence detectors.
- Accepts parallel bytes over a valid/ready handshake and serialises them MSB-first into a history/compare datapath.
- Holds the runtime pattern configuration and non-overlap/overlap mode, counts matches, and emits a registered hit pulse.

Parameters:
- DW, 8, input byte width in bits; legal range 2..16.
- MAXPW, 8, maximum pattern length; sets the history register width.
- CNTW, 8, width of the saturating match counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  stream enable.
- cfg_we  in  1  config write strobe.
- cfg_pattern  in  MAXPW  pattern; the low cfg_len bits are used, bit 0 is the last bit received.
- cfg_len  in  4  pattern length; legal range 1..MAXPW.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  byte available.
- in_data  in  DW  byte to serialise, MSB first.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- busy  out  1  high while in SHIFT.
- hit  out  1  one-cycle registered match pulse.
- hit_count  out  CNTW  saturating match count.
- cfg_err  out  1  one-cycle pulse on a rejected config write.

Behaviour:
- Reset (rstn low, asynchronous) and register defaults:
  - Clears state to IDLE; busy, hit, cfg_err, hit_count, history, fill and bit index all go to 0.
  - Config register defaults: pattern = 10101 (0x15), len = 5, overlap = 0.
- States are IDLE and SHIFT.
- in_ready = en & ~cfg_we & (state == IDLE | (state == SHIFT & bit_idx == DW-1)). This is combinational and allows back-to-back bytes with no bubble.
- IDLE to SHIFT on accept: capture in_data into the shift register and set bit_idx = 0.
- SHIFT processes one bit per cycle, bit DW-1-bit_idx, then increments bit_idx.
- On the last bit: an accept in the same cycle reloads and stays in SHIFT; otherwise return to IDLE.
- en deasserted mid-byte: the current byte completes and no new byte is accepted.
- Per processed bit b:
  - hist <= {hist[MAXPW-2:0], b}; fill <= min(fill+1, MAXPW).
  - Match when new fill >= len and the low len bits of new hist equal the low len bits of pattern.
- On match:
  - hit = 1 in the next cycle only.
  - hit_count increments and saturates at all-ones.
  - If overlap = 0, fill is cleared to 0 (history is discarded), giving non-overlapping detection.
- hit latency: a byte accepted at edge E0 has its bit 0 processed in the cycle E7..E8; a match on that bit drives hit high after E8.
- Config writes:
  - Accepted only in IDLE with cfg_len in 1..MAXPW.
  - An accepted write loads pattern, len and overlap, and clears hist, fill and hit_count.
  - A write with cfg_len = 0 or cfg_len > MAXPW, or any write while in SHIFT, is ignored and pulses cfg_err for one cycle.
- cfg_we and in_valid together in IDLE: config takes priority; in_ready is 0 that cycle.
- History persists across bytes and across IDLE gaps; only reset and accepted config writes clear it.

Optional Feature:
- Macro: SEQ_DET_CTRL_POS_EN.
- Defined:
  - Adds output hit_pos [$clog2(DW)-1:0], registered with hit, holding the in-byte index (DW-1..0) of the completing bit.
  - Adds output hit_byte [15:0], counting accepted bytes modulo 2^16 and sampled on hit.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, SHIFT);
  - MAXPW_DEF = 8;
  - DEF_PATTERN = 8'h15, DEF_LEN = 4'd5, DEF_OVERLAP = 1'b0.
- Sub-module seq_det_match holds hist, fill, the comparator and the non-overlap clear. Inputs: bit, bit_vld, cfg. Output: match.
- seq_det_ctrl keeps the handshake, serialiser, config register, counter and output registers.

Test Plan:
- Defaults, one byte 0x15 -> single hit 8 cycles after the accept edge; hit_count = 1; busy high for exactly 8 cycles.
- Defaults (non-overlap), bytes 0x55, 0x55 back-to-back -> hits on stream bits 6 and 12; hit_count = 2; no idle cycle between bytes.
- Config overlap = 1, same 0x55, 0x55 stream -> hits on bits 6, 8, 10, 12, 14, 16; hit_count = 6.
- Config rejection:
  - cfg_len = 0 in IDLE -> cfg_err pulses, config unchanged.
  - cfg_we during SHIFT -> cfg_err pulses; the in-flight byte's hits are unaffected.
- Saturation: pattern 1, len = 1, overlap = 1, 32 bytes of 0xFF -> 256 hit pulses; hit_count holds at 255.
- Reset mid-stream: rstn low at bit 3 of a byte -> immediately state IDLE with busy, hit and hit_count all 0. After release, byte 0x15 -> exactly one hit, so no stale history carries over.
